dmem_access_unit: RTL and testbench

- Data-memory access stage between the execute result (address, store data, MemOP) and a word-wide data bus with a grant/valid handshake.
- Performs RV32I byte, halfword and word loads and stores. Stores use byte enables; loads are extracted and sign- or zero-extended.
- Holds the core via `stall` until the access completes.
- Replaces the purely combinational memory path so the core can sit behind a slow or arbitrated bus.

---
 rtl/dmem_access_unit_pkg.sv | 33 +++
 rtl/dmem_access_unit_load_extend.sv | 29 ++
 rtl/dmem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: MemOP encodings,
// FSM state type and request legality helpers.
package dmem_access_unit_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT_R = 2'd2,
        S_RESP   = 2'd3
    } dmem_state_t;

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            MOP_H, MOP_HU: return addr_lo[0];
            MOP_W:         return addr_lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        case (op)
            MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a bus word and sign- or
// zero-extends it according to the MemOP.
module load_extend
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [31:0] aligned;

    // Move the addressed lane down to bit 0 so every op selects from the low bits.
    assign aligned = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = 32'h0000_0000;
        case (op)
            MOP_B:   data = {{24{aligned[7]}}, aligned[7:0]};
            MOP_H:   data = {{16{aligned[15]}}, aligned[15:0]};
            MOP_W:   data = rdata;
            MOP_BU:  data = {24'h00_0000, aligned[7:0]};
            MOP_HU:  data = {16'h0000, aligned[15:0]};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// RV32I load/store stage in front of a word-wide grant/valid data bus;
// stalls the core until the access completes, errors or times out.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             we_reg;
    logic [2:0]       op_reg;
    logic [1:0]       addr_lo_reg;
    logic             bus_req_reg;
    logic             bus_we_reg;
    logic [31:0]      bus_addr_reg;
    logic [3:0]       bus_be_reg;
    logic [31:0]      bus_wdata_reg;
    logic             resp_valid_reg;
    logic             resp_err_reg;
    logic [31:0]      resp_rdata_reg;

    logic             req_bad;
    logic [3:0]       req_span;
    logic [3:0]       span_end;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic             timeout_hit;
    logic [31:0]      load_data;

    assign req_bad = ~is_legal_op(req_op)
                   | is_misaligned(req_op, req_addr[1:0])
                   | (req_we & req_op[2]);

    always_comb begin
        req_span = 4'd4;
        case (req_op[1:0])
            2'b00:   req_span = 4'd1;
            2'b01:   req_span = 4'd2;
            default: req_span = 4'd4;
        endcase
    end

    assign span_end = {2'b00, req_addr[1:0]} + req_span;

    // A lane is enabled when it falls inside [addr_lo, addr_lo + size).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [3:0] LANE = 4'(gi);
            assign be_next[gi] = (LANE >= {2'b00, req_addr[1:0]}) && (LANE < span_end);
        end
    endgenerate

    assign wdata_next  = req_wdata << {req_addr[1:0], 3'b000};
    assign timeout_hit = (cnt_reg == CNT_LAST);

    load_extend u_load_extend (
        .rdata   (bus_rdata),
        .addr_lo (addr_lo_reg),
        .op      (op_reg),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            op_reg         <= MOP_B;
            addr_lo_reg    <= 2'b00;
            bus_req_reg    <= 1'b0;
            bus_we_reg     <= 1'b0;
            bus_addr_reg   <= 32'h0000_0000;
            bus_be_reg     <= 4'b0000;
            bus_wdata_reg  <= 32'h0000_0000;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= 32'h0000_0000;
        end else begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg      <= req_we;
                        op_reg      <= req_op;
                        addr_lo_reg <= req_addr[1:0];
                        cnt_reg     <= '0;
                        if (req_bad) begin
                            state_reg      <= S_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'h0000_0000;
                        end else begin
                            state_reg     <= S_ISSUE;
                            bus_req_reg   <= 1'b1;
                            bus_we_reg    <= req_we;
                            bus_addr_reg  <= {req_addr[31:2], 2'b00};
                            bus_be_reg    <= be_next;
                            bus_wdata_reg <= wdata_next;
                        end
                    end
                end
                S_ISSUE: begin
                    // Grant has priority over a timeout landing in the same cycle.
                    if (bus_gnt) begin
                        bus_req_reg <= 1'b0;
                        bus_we_reg  <= 1'b0;
                        cnt_reg     <= '0;
                        if (we_reg) begin
                            state_reg      <= S_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= 32'h0000_0000;
                        end else begin
                            state_reg <= S_WAIT_R;
                        end
                    end else if (timeout_hit) begin
                        bus_req_reg    <= 1'b0;
                        bus_we_reg     <= 1'b0;
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        resp_rdata_reg <= 32'h0000_0000;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_WAIT_R: begin
                    if (bus_rvalid) begin
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                    end else if (timeout_hit) begin
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_err_reg   <= 1'b1;
                        resp_rdata_reg <= 32'h0000_0000;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_reg == S_IDLE);
    // The core is released on the response cycle itself.
    assign stall      = (req_valid | (state_reg != S_IDLE)) & (state_reg != S_RESP);
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign bus_req    = bus_req_reg;
    assign bus_we     = bus_we_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_be     = bus_be_reg;
    assign bus_wdata  = bus_wdata_reg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit: directed and random loads/stores,
// a reactive bus model and a response monitor checked against a reference model.
module tb_dmem_access_unit;

    localparam int TO    = 64;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid;
    logic [31:0] bus_rdata = 32'h0;
    logic        rvalid_resp = 1'b0;
    logic        rvalid_drv = 1'b0;

    assign bus_rvalid = rvalid_resp | rvalid_drv;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    typedef struct {
        bit        we;
        bit [2:0]  op;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        gd;
        int        rd;
        bit [31:0] rdata;
    } txn_t;

    typedef struct {
        bit        err;
        bit [31:0] rdata;
        int        cyc;
    } rexp_t;

    txn_t  bus_q[$];
    rexp_t resp_q[$];
    int    n_chk = 0;
    int    n_bad = 0;
    int    n_resp = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input bit [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_bad(input txn_t t);
        bit legal;
        legal = (t.op == 3'd0) || (t.op == 3'd1) || (t.op == 3'd2) || (t.op == 3'd4) || (t.op == 3'd5);
        if (!legal) return 1'b1;
        if ((t.addr % m_size(t.op)) != 0) return 1'b1;
        return t.we && (t.op >= 3'd4);
    endfunction

    function automatic bit [31:0] m_load(input txn_t t);
        int        off;
        bit [31:0] w;
        byte       sb;
        shortint   sh;
        int        v;
        off = int'(t.addr % 4);
        w   = t.rdata >> (8 * off);
        sb  = w[7:0];
        sh  = w[15:0];
        case (t.op)
            3'd0:    v = sb;
            3'd1:    v = sh;
            3'd4:    v = int'(w & 32'h0000_00FF);
            3'd5:    v = int'(w & 32'h0000_FFFF);
            default: v = int'(t.rdata);
        endcase
        return 32'(v);
    endfunction

    function automatic bit [3:0] m_be(input txn_t t);
        int off;
        off = int'(t.addr % 4);
        return 4'(((1 << m_size(t.op)) - 1) << off);
    endfunction

    function automatic bit [31:0] m_wdata(input txn_t t);
        return t.wdata << (8 * int'(t.addr % 4));
    endfunction

    function automatic bit m_err(input txn_t t);
        return m_bad(t) || (t.gd >= TO) || (!t.we && t.rd >= TO);
    endfunction

    // Cycles from the req_valid cycle to the resp_valid cycle.
    function automatic int m_lat(input txn_t t);
        if (m_bad(t)) return 1;
        if (t.gd >= TO) return 1 + TO;
        if (t.we) return 2 + t.gd;
        if (t.rd >= TO) return 2 + t.gd + TO;
        return 3 + t.gd + t.rd;
    endfunction

    function automatic txn_t mk(input bit we, input bit [2:0] op, input bit [31:0] addr,
                                input bit [31:0] wdata, input int gd, input int rd,
                                input bit [31:0] rdata);
        txn_t t;
        t.we = we; t.op = op; t.addr = addr; t.wdata = wdata;
        t.gd = gd; t.rd = rd; t.rdata = rdata;
        return t;
    endfunction

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 31));
        if (r == 0) return NEVER;
        if (r == 1) return TO - 1;
        return int'($urandom_range(0, 4));
    endfunction

    // ---------------- response monitor ----------------
    initial begin
        rexp_t e;
        forever begin
            @(negedge clk);
            if (rst && resp_valid) begin
                n_resp++;
                if (resp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got err=%0b rdata=%h expected no response", resp_err, resp_rdata);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_stall", 32'(stall), 32'd0);
                    check("resp_ready", 32'(req_ready), 32'd0);
                end
            end
        end
    end

    // ---------------- bus model ----------------
    initial begin
        txn_t t;
        bit   hold_ok;
        int   gd_eff;
        int   n;
        forever begin
            @(negedge clk);
            bus_gnt     = 1'b0;
            rvalid_resp = 1'b0;
            bus_rdata   = $urandom;
            if (rst && bus_req) begin
                if (bus_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL unexpected_bus_req: got bus_req=1 addr=%h expected no bus activity", bus_addr);
                    n = 0;
                    while (bus_req && n < 200) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    t = bus_q.pop_front();
                    check("bus_addr", bus_addr, {t.addr[31:2], 2'b00});
                    check("bus_we", 32'(bus_we), 32'(t.we));
                    check("bus_be", 32'(bus_be), 32'(m_be(t)));
                    if (t.we) check("bus_wdata", bus_wdata, m_wdata(t));
                    hold_ok = 1'b1;
                    gd_eff  = (t.gd >= TO) ? TO : t.gd;
                    for (int i = 0; i < gd_eff; i++) begin
                        if (!(bus_req === 1'b1 && bus_addr === {t.addr[31:2], 2'b00} && stall === 1'b1))
                            hold_ok = 1'b0;
                        @(negedge clk);
                    end
                    if (gd_eff > 0) check("issue_hold", 32'(hold_ok), 32'd1);
                    if (t.gd >= TO) begin
                        check("req_drop", 32'(bus_req), 32'd0);
                    end else begin
                        bus_gnt = 1'b1;
                        @(negedge clk);
                        bus_gnt = 1'b0;
                        if (!t.we && t.rd < TO) begin
                            repeat (t.rd) @(negedge clk);
                            rvalid_resp = 1'b1;
                            bus_rdata   = t.rdata;
                            @(negedge clk);
                            rvalid_resp = 1'b0;
                            bus_rdata   = $urandom;
                        end
                    end
                end
            end else if (rst && !stall && $urandom_range(0, 3) == 0) begin
                // Stray handshakes while idle or responding must be ignored.
                bus_gnt     = 1'b1;
                rvalid_resp = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input txn_t t, input bit want_resp);
        rexp_t e;
        if (!m_bad(t)) bus_q.push_back(t);
        if (want_resp) begin
            e.err   = m_err(t);
            e.rdata = (e.err || t.we) ? 32'h0 : m_load(t);
            e.cyc   = cyc + m_lat(t);
            resp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_we    = t.we;
        req_op    = t.op;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        #1;
        check("stall_on_req", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_resp(input int start);
        int i;
        i = 0;
        while (n_resp == start && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("resp_arrived", 32'(n_resp != start), 32'd1);
        check("ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic run(input txn_t t);
        int start;
        start = n_resp;
        issue(t, 1'b1);
        wait_resp(start);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        txn_t    t;
        int      start;
        bit [2:0] legal_ops[5];
        legal_ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        #12;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        run(mk(1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0));
        run(mk(0, 3'd0, 32'h0000_2001, 32'h0, 0, 0, 32'h1234_80FF));
        run(mk(0, 3'd4, 32'h0000_2001, 32'h0, 0, 1, 32'h1234_80FF));
        run(mk(0, 3'd5, 32'h0000_2002, 32'h0, 1, 0, 32'h9ABC_5678));
        run(mk(0, 3'd1, 32'h0000_2002, 32'h0, 0, 2, 32'h9ABC_5678));
        run(mk(0, 3'd2, 32'h0000_3002, 32'h0, 0, 0, 32'h0));
        run(mk(0, 3'd2, 32'h0000_3004, 32'h0, 5, 1, 32'hCAFE_F00D));
        run(mk(0, 3'd2, 32'h0000_3008, 32'h0, 0, NEVER, 32'h0));
        run(mk(1, 3'd2, 32'h0000_300C, 32'h1111_2222, NEVER, 0, 32'h0));
        run(mk(0, 3'd1, 32'h0000_4002, 32'h0, 0, TO - 1, 32'h8001_7FFF));
        run(mk(1, 3'd1, 32'h0000_4002, 32'h0000_BEEF, TO - 1, 0, 32'h0));
        run(mk(1, 3'd4, 32'h0000_5000, 32'h0000_0012, 0, 0, 32'h0));
        run(mk(0, 3'd3, 32'h0000_5000, 32'h0, 0, 0, 32'h0));
        run(mk(1, 3'd1, 32'h0000_5003, 32'h0000_3456, 0, 0, 32'h0));

        // Reset while a granted read is outstanding.
        issue(mk(0, 3'd2, 32'h0000_6000, 32'h0, 0, NEVER, 32'h0), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_bus_req", 32'(bus_req), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        start = n_resp;
        rvalid_drv = 1'b1;
        @(posedge clk);
        #1;
        rvalid_drv = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("late_rvalid_resp", n_resp - start, 32'd0);
        check("late_rvalid_bus_req", 32'(bus_req), 32'd0);

        for (int k = 0; k < 150; k++) begin
            t.we    = 1'($urandom_range(0, 1));
            t.op    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) t.op = legal_ops[$urandom_range(0, 4)];
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.gd    = pick_delay();
            t.rd    = pick_delay();
            run(t);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("resp_q_empty", resp_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
